afifo_wr_arb: RTL

- Write-domain controller for the async FIFO. Shares a single FIFO write port between N requesters using packet-locked round-robin arbitration.
- Owns the write pointer in binary and Gray form, drives the dual-port RAM write strobe, address and data, and produces the full flag.
- Full is computed against the read pointer after it has been synchronized into wclk by the two-flop read-to-write synchronizer. This block only consumes that synchronized value.

---
 rtl/afifo_wr_arb.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/afifo_wr_arb.sv
// Async FIFO write-side controller: packet-locked round-robin arbitration of N requesters
// onto one RAM write port, plus write pointer and full flag. Optional: AFIFO_WR_ALMOST_FULL_EN.
module afifo_wr_arb #(
  parameter int unsigned N     = 2,
  parameter int unsigned DW    = 32,
  parameter int unsigned ASIZE = 4
`ifdef AFIFO_WR_ALMOST_FULL_EN
  ,
  parameter int unsigned AFULL_THRESH = (1 << ASIZE) - 2
`endif
) (
  input  logic            wclk,
  input  logic            wrst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  input  logic [ASIZE:0]  wq2_rptr,
  output logic [ASIZE:0]  wptr,
  output logic [ASIZE-1:0] waddr,
  output logic [DW-1:0]   wdata,
  output logic            winc,
  output logic            wfull,
  output logic [N-1:0]    grant
`ifdef AFIFO_WR_ALMOST_FULL_EN
  ,
  output logic            walmost_full
`endif
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   lock_q, lock_d;
  logic [ASIZE:0]  wbin_q, wbin_d;
  logic [ASIZE:0]  wgray_q, wgray_d;
  logic            wfull_q, wfull_d;

  logic [IW-1:0]   sel;
  logic [IW-1:0]   sel_inc;
  logic            grant_any;
  logic            accept;
  logic            sel_last;

  // Round-robin search: rotate the valid vector so bit k is requester (rr_q + k) mod N.
  always_comb begin
    logic [2*N-1:0] rot;
    logic [IW:0]    cand;
    rot       = {req_valid, req_valid} >> rr_q;
    cand      = '0;
    sel       = lock_q;
    grant_any = 1'b0;
    if (state_q == StBurst) begin
      grant_any = 1'b1;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!grant_any && rot[k]) begin
          cand = {1'b0, rr_q} + (IW+1)'(k);
          if (cand >= (IW+1)'(N)) begin
            cand = cand - (IW+1)'(N);
          end
          sel       = cand[IW-1:0];
          grant_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    accept = grant_any & req_valid[sel] & ~wfull_q;
    grant  = '0;
    if (grant_any) begin
      grant[sel] = 1'b1;
    end
    req_ready = accept ? grant : '0;
    winc      = accept;
    waddr     = wbin_q[ASIZE-1:0];
    sel_last  = req_last[sel];
    wdata     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == IW'(i)) begin
        wdata = req_data[i*DW +: DW];
      end
    end
    sel_inc = (sel == IW'(N-1)) ? '0 : sel + IW'(1);

    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (sel_last) begin
            rr_d = sel_inc;
          end else begin
            state_d = StBurst;
            lock_d  = sel;
          end
        end
        StBurst: begin
          // In a burst sel equals lock_q, so sel_inc is lock_q + 1 mod N.
          if (sel_last) begin
            state_d = StIdle;
            rr_d    = sel_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    wbin_d  = wbin_q + (ASIZE+1)'(accept);
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    // Full when the write pointer is exactly one lap ahead of the synchronized read pointer.
    wfull_d = (wgray_d == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= StIdle;
      rr_q    <= '0;
      lock_q  <= '0;
      wbin_q  <= '0;
      wgray_q <= '0;
      wfull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      wfull_q <= wfull_d;
    end
  end

  assign wptr  = wgray_q;
  assign wfull = wfull_q;

`ifdef AFIFO_WR_ALMOST_FULL_EN
  logic [ASIZE:0] rbin;
  logic [ASIZE:0] afull_diff;
  logic           walmost_full_q, walmost_full_d;

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
    afull_diff     = wbin_d - rbin;
    walmost_full_d = (32'(afull_diff) >= AFULL_THRESH);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      walmost_full_q <= 1'b0;
    end else begin
      walmost_full_q <= walmost_full_d;
    end
  end

  assign walmost_full = walmost_full_q;
`else
  // Default build carries no fill-level tracking beyond the full flag.
`endif

endmodule
